// File: rtl/literal_lookup_table_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : literal_lookup_table_pkg
//  Purpose  : Shared definitions for the literal lookup table: table state
//             encoding and the entry width / table depth derivations.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package literal_lookup_table_pkg;

    // Table lifecycle: CLEAR sweeps every entry to zero, RUN serves traffic.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } lut_state_e;

    // One entry is {clause-table address, clause mask}.
    function automatic int lut_width(input int clause_table_address_width,
                                     input int clause_count);
        return clause_table_address_width + clause_count;
    endfunction

    function automatic int lut_depth(input int literal_address_width);
        return 1 << literal_address_width;
    endfunction

endpackage : literal_lookup_table_pkg
`default_nettype wire

// File: rtl/literal_lookup_table_read_channel.sv
`default_nettype none
// ============================================================================
//  Module   : lut_read_channel
//  Purpose  : One read channel of the literal lookup table. Registers the
//             looked-up entry on accept (1-cycle latency) and holds it while
//             the consumer stalls.
//  Ports    : clk_i/rst_i    clock, synchronous active-high reset
//             flush_i        discard any pending response (table clear)
//             run_i          table is in RUN and may accept requests
//             rd_valid_i     request valid      rd_ready_o  request ready
//             entry_i        entry data for this channel's request address
//             out_valid_o    response valid     out_ready_i response ready
//             addr_o/mask_o  registered response fields
//  Revision : 1.0  initial release
// ============================================================================
module lut_read_channel
    import literal_lookup_table_pkg::*;
#(
    parameter int CLAUSE_COUNT               = 20,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             flush_i,
    input  logic                                             run_i,
    input  logic                                             rd_valid_i,
    output logic                                             rd_ready_o,
    input  logic [CLAUSE_TABLE_ADDRESS_WIDTH+CLAUSE_COUNT-1:0] entry_i,
    output logic                                             out_valid_o,
    input  logic                                             out_ready_i,
    output logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0]            addr_o,
    output logic [CLAUSE_COUNT-1:0]                          mask_o
);

    localparam int WIDTH = lut_width(CLAUSE_TABLE_ADDRESS_WIDTH, CLAUSE_COUNT);

    logic                                  r_valid;
    logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] r_addr;
    logic [CLAUSE_COUNT-1:0]               r_mask;
    logic                                  w_accept;

    // A new request may enter when the output slot is empty or being drained.
    assign rd_ready_o = run_i && (!r_valid || out_ready_i);
    assign w_accept   = rd_valid_i && rd_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_mask  <= '0;
        end else if (flush_i) begin
            // Pending response is dropped; the data fields are don't-care.
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_addr  <= entry_i[WIDTH-1 -: CLAUSE_TABLE_ADDRESS_WIDTH];
            r_mask  <= entry_i[CLAUSE_COUNT-1:0];
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_valid;
    assign addr_o      = r_addr;
    assign mask_o      = r_mask;

endmodule : lut_read_channel
`default_nettype wire

// File: rtl/literal_lookup_table.sv
`default_nettype none
// ============================================================================
//  Module   : literal_lookup_table
//  Purpose  : Multi-port literal lookup table. After reset or clear it sweeps
//             every entry to zero (CLEAR), then serves NUM_RD_PORTS
//             independent valid/ready read channels with 1-cycle latency and
//             accepts setup writes with write-first bypass (RUN).
//  Ports    : clk_i, rst_i          clock, synchronous active-high reset
//             clear_i               pulse: restart the clear sweep
//             init_done_o           table is in RUN
//             axi_wr_*              setup write strobe/address/data {addr,mask}
//             rd_valid_i/rd_addr_i  packed per-channel requests
//             rd_ready_o            per-channel request ready
//             out_valid_o/out_ready_i, addr_o, mask_o  packed responses
//  Revision : 1.0  initial release
// ============================================================================
module literal_lookup_table
    import literal_lookup_table_pkg::*;
#(
    parameter int CLAUSE_COUNT               = 20,
    parameter int LITERAL_ADDRESS_WIDTH      = 12,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11,
    parameter int NUM_RD_PORTS               = 2
) (
    input  logic                                               clk_i,
    input  logic                                               rst_i,
    input  logic                                               clear_i,
    output logic                                               init_done_o,
    input  logic                                               axi_wr_en_i,
    input  logic [LITERAL_ADDRESS_WIDTH-1:0]                   axi_wr_addr_i,
    input  logic [CLAUSE_TABLE_ADDRESS_WIDTH+CLAUSE_COUNT-1:0] axi_wr_data_i,
    input  logic [NUM_RD_PORTS-1:0]                            rd_valid_i,
    input  logic [NUM_RD_PORTS*LITERAL_ADDRESS_WIDTH-1:0]      rd_addr_i,
    output logic [NUM_RD_PORTS-1:0]                            rd_ready_o,
    output logic [NUM_RD_PORTS-1:0]                            out_valid_o,
    input  logic [NUM_RD_PORTS-1:0]                            out_ready_i,
    output logic [NUM_RD_PORTS*CLAUSE_TABLE_ADDRESS_WIDTH-1:0] addr_o,
    output logic [NUM_RD_PORTS*CLAUSE_COUNT-1:0]               mask_o
);

    localparam int WIDTH = lut_width(CLAUSE_TABLE_ADDRESS_WIDTH, CLAUSE_COUNT);
    localparam int DEPTH = lut_depth(LITERAL_ADDRESS_WIDTH);

    localparam logic [LITERAL_ADDRESS_WIDTH-1:0] c_LAST_ENTRY = '1;
    localparam logic [LITERAL_ADDRESS_WIDTH-1:0] c_ONE        = LITERAL_ADDRESS_WIDTH'(1);

    lut_state_e                       r_state;
    logic [LITERAL_ADDRESS_WIDTH-1:0] r_sweep_cnt;
    logic [WIDTH-1:0]                 r_table [DEPTH];

    logic                             w_run;
    logic                             w_wr_fire;
    logic                             w_tbl_we;
    logic [LITERAL_ADDRESS_WIDTH-1:0] w_tbl_addr;
    logic [WIDTH-1:0]                 w_tbl_data;

    assign w_run       = (r_state == ST_RUN);
    assign init_done_o = w_run;
    // A clear pulse wins over a coincident setup write.
    assign w_wr_fire   = w_run && axi_wr_en_i && !clear_i;

    // ------------------------------------------------------------------
    // Lifecycle FSM and sweep counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_state     <= ST_CLEAR;
            r_sweep_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_sweep_cnt <= r_sweep_cnt + c_ONE;
                    if (r_sweep_cnt == c_LAST_ENTRY) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state     <= ST_CLEAR;
                    r_sweep_cnt <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Single table write port: sweep zeros in CLEAR, setup writes in RUN.
    // Setup writes during CLEAR are ignored by construction.
    // ------------------------------------------------------------------
    always_comb begin
        w_tbl_we   = 1'b0;
        w_tbl_addr = axi_wr_addr_i;
        w_tbl_data = axi_wr_data_i;
        if (!rst_i && !clear_i) begin
            if (r_state == ST_CLEAR) begin
                w_tbl_we   = 1'b1;
                w_tbl_addr = r_sweep_cnt;
                w_tbl_data = '0;
            end else if (w_wr_fire) begin
                w_tbl_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_tbl_we) begin
            r_table[w_tbl_addr] <= w_tbl_data;
        end
    end

    // ------------------------------------------------------------------
    // Read channels
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_ch
        logic [LITERAL_ADDRESS_WIDTH-1:0] w_rd_addr;
        logic [WIDTH-1:0]                 w_entry;

        assign w_rd_addr = rd_addr_i[p*LITERAL_ADDRESS_WIDTH +: LITERAL_ADDRESS_WIDTH];
        // Write-first: a same-cycle write to the requested entry is returned.
        assign w_entry   = (w_wr_fire && (axi_wr_addr_i == w_rd_addr))
                         ? axi_wr_data_i : r_table[w_rd_addr];

        lut_read_channel #(
            .CLAUSE_COUNT               (CLAUSE_COUNT),
            .CLAUSE_TABLE_ADDRESS_WIDTH (CLAUSE_TABLE_ADDRESS_WIDTH)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .flush_i     (clear_i),
            .run_i       (w_run),
            .rd_valid_i  (rd_valid_i[p]),
            .rd_ready_o  (rd_ready_o[p]),
            .entry_i     (w_entry),
            .out_valid_o (out_valid_o[p]),
            .out_ready_i (out_ready_i[p]),
            .addr_o      (addr_o[p*CLAUSE_TABLE_ADDRESS_WIDTH +: CLAUSE_TABLE_ADDRESS_WIDTH]),
            .mask_o      (mask_o[p*CLAUSE_COUNT +: CLAUSE_COUNT])
        );
    end

endmodule : literal_lookup_table
`default_nettype wire

// File: tb/tb_literal_lookup_table.sv
`default_nettype none
// ============================================================================
//  Module   : tb_literal_lookup_table
//  Purpose  : Self-checking bench for literal_lookup_table: behavioural table
//             model with per-cycle compare, plus directed literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_literal_lookup_table;

    localparam int CC    = 20;
    localparam int AW    = 12;
    localparam int CAW   = 11;
    localparam int NP    = 2;
    localparam int W     = CAW + CC;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i, clear_i, init_done_o, axi_wr_en_i;
    logic [AW-1:0]     axi_wr_addr_i;
    logic [W-1:0]      axi_wr_data_i;
    logic [NP-1:0]     rd_valid_i, rd_ready_o, out_valid_o, out_ready_i;
    logic [NP*AW-1:0]  rd_addr_i;
    logic [NP*CAW-1:0] addr_o;
    logic [NP*CC-1:0]  mask_o;

    literal_lookup_table #(
        .CLAUSE_COUNT(CC), .LITERAL_ADDRESS_WIDTH(AW),
        .CLAUSE_TABLE_ADDRESS_WIDTH(CAW), .NUM_RD_PORTS(NP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .init_done_o(init_done_o),
        .axi_wr_en_i(axi_wr_en_i), .axi_wr_addr_i(axi_wr_addr_i),
        .axi_wr_data_i(axi_wr_data_i), .rd_valid_i(rd_valid_i),
        .rd_addr_i(rd_addr_i), .rd_ready_o(rd_ready_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .addr_o(addr_o), .mask_o(mask_o)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: the table is an array that is zero after any
    // reset/clear; it becomes usable DEPTH cycles later.
    // ------------------------------------------------------------------
    logic [W-1:0]   m_mem [DEPTH];
    bit             m_run;
    int             m_left;
    bit [NP-1:0]    m_valid;
    logic [CAW-1:0] m_addr [NP];
    logic [CC-1:0]  m_mask [NP];

    always @(posedge clk) begin : model
        bit [NP-1:0]   rdy;
        logic [AW-1:0] a;
        logic [W-1:0]  e;
        for (int p = 0; p < NP; p++) rdy[p] = m_run && (!m_valid[p] || out_ready_i[p]);
        if (rst_i || clear_i) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            m_run   = 1'b0;
            m_left  = DEPTH;
            m_valid = '0;
            if (rst_i) begin
                for (int p = 0; p < NP; p++) begin
                    m_addr[p] = '0;
                    m_mask[p] = '0;
                end
            end
        end else if (!m_run) begin
            m_left--;
            if (m_left == 0) m_run = 1'b1;
        end else begin
            for (int p = 0; p < NP; p++) begin
                if (rd_valid_i[p] && rdy[p]) begin
                    a = rd_addr_i[p*AW +: AW];
                    e = (axi_wr_en_i && axi_wr_addr_i == a) ? axi_wr_data_i : m_mem[a];
                    m_valid[p] = 1'b1;
                    m_addr[p]  = e[W-1:CC];
                    m_mask[p]  = e[CC-1:0];
                end else if (out_ready_i[p]) begin
                    m_valid[p] = 1'b0;
                end
            end
            if (axi_wr_en_i) m_mem[axi_wr_addr_i] = axi_wr_data_i;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("init_done", 64'(init_done_o), 64'(m_run));
            for (int p = 0; p < NP; p++) begin
                check($sformatf("rd_ready[%0d]", p), 64'(rd_ready_o[p]),
                      64'(m_run && (!m_valid[p] || out_ready_i[p])));
                check($sformatf("out_valid[%0d]", p), 64'(out_valid_o[p]), 64'(m_valid[p]));
                if (m_valid[p]) begin
                    check($sformatf("addr[%0d]", p), 64'(addr_o[p*CAW +: CAW]), 64'(m_addr[p]));
                    check($sformatf("mask[%0d]", p), 64'(mask_o[p*CC +: CC]), 64'(m_mask[p]));
                end
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        axi_wr_en_i = 1'b0;
        rd_valid_i  = '0;
        out_ready_i = '1;
    endtask

    task automatic rand_phase(input int cycles, input int max_addr);
        for (int c = 0; c < cycles; c++) begin
            axi_wr_en_i   = ($urandom_range(0, 3) == 0);
            axi_wr_addr_i = AW'($urandom_range(0, max_addr));
            axi_wr_data_i = W'($urandom());
            rd_valid_i    = NP'($urandom());
            out_ready_i   = NP'($urandom());
            for (int p = 0; p < NP; p++)
                rd_addr_i[p*AW +: AW] = AW'($urandom_range(0, max_addr));
            tick();
        end
        idle_inputs();
        tick();
    endtask

    // Wait for init_done, bounded; returns cycles counted.
    task automatic wait_sweep(output int n, input bit poke_write);
        n = 0;
        while (!init_done_o && n < 5000) begin
            rd_valid_i  = NP'($urandom());
            out_ready_i = NP'($urandom());
            axi_wr_en_i = poke_write && (n == 4000);
            axi_wr_addr_i = 12'h020;
            axi_wr_data_i = 31'h5A5A_5A5A;
            tick();
            n++;
        end
        idle_inputs();
    endtask

    initial begin
        int n;
        rst_i = 1'b1; clear_i = 1'b0;
        axi_wr_en_i = 1'b0; axi_wr_addr_i = '0; axi_wr_data_i = '0;
        rd_valid_i = '0; rd_addr_i = '0; out_ready_i = '0;

        // Reset state
        tick(); chk_en = 1'b1;
        tick(); tick();
        check("reset init_done", 64'(init_done_o), 64'(0));
        check("reset rd_ready",  64'(rd_ready_o),  64'(0));
        check("reset out_valid", 64'(out_valid_o), 64'(0));
        check("reset addr",      64'(addr_o),      64'(0));
        check("reset mask",      64'(mask_o),      64'(0));

        // Sweep length after reset, with a write attempt late in CLEAR
        rst_i = 1'b0;
        wait_sweep(n, 1'b1);
        check("reset sweep cycles", 64'(n), 64'(4096));

        // The write during CLEAR must not have landed
        rd_valid_i = 2'b10; rd_addr_i = {12'h020, 12'h000};
        tick();
        check("clear-write ignored valid", 64'(out_valid_o[1]), 64'(1));
        check("clear-write ignored data",  64'({addr_o[CAW +: CAW], mask_o[CC +: CC]}), 64'(0));
        idle_inputs(); tick();

        // Basic write then read
        axi_wr_en_i = 1'b1; axi_wr_addr_i = 12'h003; axi_wr_data_i = {11'h7FF, 20'h00005};
        tick();
        axi_wr_en_i = 1'b0; rd_valid_i = 2'b01; rd_addr_i = {12'h000, 12'h003};
        tick();
        check("read valid0", 64'(out_valid_o[0]), 64'(1));
        check("read addr0",  64'(addr_o[0 +: CAW]), 64'(11'h7FF));
        check("read mask0",  64'(mask_o[0 +: CC]),  64'(20'h00005));

        // Both channels stalled for 3 cycles
        rd_valid_i = 2'b11; rd_addr_i = {12'h003, 12'h003}; out_ready_i = 2'b00;
        tick();
        rd_valid_i = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall valid",   64'(out_valid_o), 64'(2'b11));
            check("stall rdready", 64'(rd_ready_o),  64'(2'b00));
            check("stall addr",    64'(addr_o), 64'({11'h7FF, 11'h7FF}));
            check("stall mask",    64'(mask_o), 64'({20'h00005, 20'h00005}));
        end
        out_ready_i = 2'b11; #1;
        check("release rdready", 64'(rd_ready_o), 64'(2'b11));
        tick();
        check("taken valid",   64'(out_valid_o), 64'(2'b00));
        check("taken rdready", 64'(rd_ready_o),  64'(2'b11));

        // Write-first bypass on channel 1
        axi_wr_en_i = 1'b1; axi_wr_addr_i = 12'h010; axi_wr_data_i = {11'h001, 20'h00001};
        rd_valid_i = 2'b10; rd_addr_i = {12'h010, 12'h000};
        tick();
        check("bypass valid1", 64'(out_valid_o[1]), 64'(1));
        check("bypass addr1",  64'(addr_o[CAW +: CAW]), 64'(11'h001));
        check("bypass mask1",  64'(mask_o[CC +: CC]),   64'(20'h00001));
        idle_inputs(); tick();

        // Randomized traffic on a small address window to force collisions
        rand_phase(3000, 15);

        // Clear with a response pending
        rd_valid_i = 2'b01; rd_addr_i = {12'h000, 12'h003}; out_ready_i = 2'b00;
        tick();
        check("pending before clear", 64'(out_valid_o[0]), 64'(1));
        rd_valid_i = 2'b00; clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("clear drops valid", 64'(out_valid_o), 64'(0));
        check("clear init_done",   64'(init_done_o), 64'(0));
        wait_sweep(n, 1'b0);
        check("clear sweep cycles", 64'(n), 64'(4096));
        rd_valid_i = 2'b01; rd_addr_i = {12'h000, 12'h003};
        tick();
        check("post-clear valid0", 64'(out_valid_o[0]), 64'(1));
        check("post-clear data0",  64'({addr_o[0 +: CAW], mask_o[0 +: CC]}), 64'(0));
        idle_inputs(); tick();

        // More randomized traffic over a wider window
        rand_phase(1500, 63);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_literal_lookup_table
`default_nettype wire
